// File: rtl/vector_ctrl_pkg.sv
// Control-word type, ALU/opcode constants and the ISA decode table for the vector sequencer.
// Opcodes 0x00-0x10 are defined; everything above decodes as the all-zero NOP word.
package vector_ctrl_pkg;

    typedef struct packed {
        logic       use_scalar_alu;
        logic       is_scalar_output;
        logic       is_scalar_reg1;
        logic       is_scalar_reg2;
        logic       result_selector_wb;
        logic       we_scalar_wb;
        logic       we_vector_wb;
        logic       wr_mem_m;
        logic       use_imm;
        logic       out_flag_m;
        logic [2:0] alu_control;
    } ctrl_word_t;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluMul = 3'd2;
    localparam logic [2:0] AluAnd = 3'd3;
    localparam logic [2:0] AluOr  = 3'd4;
    localparam logic [2:0] AluXor = 3'd5;
    localparam logic [2:0] AluSll = 3'd6;
    localparam logic [2:0] AluSlt = 3'd7;

    localparam logic [4:0] OpNop    = 5'h00;
    localparam logic [4:0] OpVadd   = 5'h01;
    localparam logic [4:0] OpVsub   = 5'h02;
    localparam logic [4:0] OpVmul   = 5'h03;
    localparam logic [4:0] OpVaddi  = 5'h04;
    localparam logic [4:0] OpVsubs  = 5'h05;
    localparam logic [4:0] OpVand   = 5'h06;
    localparam logic [4:0] OpVld    = 5'h07;
    localparam logic [4:0] OpVst    = 5'h08;
    localparam logic [4:0] OpVred   = 5'h09;
    localparam logic [4:0] OpSadd   = 5'h0A;
    localparam logic [4:0] OpSaddi  = 5'h0B;
    localparam logic [4:0] OpSld    = 5'h0C;
    localparam logic [4:0] OpSst    = 5'h0D;
    localparam logic [4:0] OpVslt   = 5'h0E;
    localparam logic [4:0] OpVor    = 5'h0F;
    localparam logic [4:0] OpVbcast = 5'h10;

    localparam int unsigned NumOpcodes = 17;
    localparam ctrl_word_t  CtrlNop    = '0;

    // Flag order: scalar_alu, scalar_out, sreg1, sreg2, res_sel, we_s, we_v, wr_mem, imm, flag
    localparam ctrl_word_t DecodeTable [NumOpcodes] = '{
        ctrl_word_t'({10'b0000000000, AluAdd}),
        ctrl_word_t'({10'b0000001000, AluAdd}),
        ctrl_word_t'({10'b0000001000, AluSub}),
        ctrl_word_t'({10'b0000001000, AluMul}),
        ctrl_word_t'({10'b0000001010, AluAdd}),
        ctrl_word_t'({10'b0001001000, AluSub}),
        ctrl_word_t'({10'b0000001000, AluAnd}),
        ctrl_word_t'({10'b0000101010, AluAdd}),
        ctrl_word_t'({10'b0000000110, AluAdd}),
        ctrl_word_t'({10'b0100010000, AluAdd}),
        ctrl_word_t'({10'b1100010000, AluAdd}),
        ctrl_word_t'({10'b1100010010, AluAdd}),
        ctrl_word_t'({10'b1100110010, AluAdd}),
        ctrl_word_t'({10'b1000000110, AluAdd}),
        ctrl_word_t'({10'b0000000001, AluSlt}),
        ctrl_word_t'({10'b0000001000, AluOr}),
        ctrl_word_t'({10'b0010001000, AluOr})
    };

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode: table lookup into a control word, flagging undefined opcodes.
module opcode_decoder
    import vector_ctrl_pkg::*;
#(
    parameter int unsigned OpcodeWidth = 5
) (
    input  logic [OpcodeWidth-1:0] opcode_i,
    output ctrl_word_t             ctrl_o,
    output logic                   illegal_o
);

    logic [31:0] op_ext;

    always_comb begin
        op_ext    = 32'(opcode_i);
        ctrl_o    = CtrlNop;
        illegal_o = 1'b1;
        for (int unsigned i = 0; i < NumOpcodes; i++) begin
            if (op_ext == i) begin
                ctrl_o    = DecodeTable[i];
                illegal_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vector_control_sequencer.sv
// Issues decoded control words to execute, repeating vector ops over VECTOR_LANES/ALU_LANES beats.
// Optional ILLEGAL_OP_TRAP_EN adds an illegal-opcode trap and a sticky illegalStickyE output.
module vector_control_sequencer
    import vector_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 5,
    parameter int unsigned VECTOR_LANES = 8,
    parameter int unsigned ALU_LANES    = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            validD,
    input  logic [OPCODE_WIDTH-1:0]         opcodeD,
    output logic                            readyD,
    input  logic                            stallE,
    input  logic                            flushE,
    output logic                            useScalarAluE,
    output logic                            isScalarOutputE,
    output logic                            isScalarReg1E,
    output logic                            isScalarReg2E,
    output logic                            resultSelectorWBE,
    output logic                            writeEnableScalarWBE,
    output logic                            writeEnableVectorWBE,
    output logic                            writeToMemoryEnableME,
    output logic                            useInmediateE,
    output logic                            outFlagME,
    output logic [2:0]                      aluControlE,
    output logic                            validE,
    output logic [$clog2(VECTOR_LANES)-1:0] laneBaseE,
    output logic                            lastBeatE,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic                            illegalStickyE,
`endif
    output logic                            illegalOpE
);

    localparam int unsigned Beats    = VECTOR_LANES / ALU_LANES;
    localparam int unsigned BeatW    = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned LaneW    = $clog2(VECTOR_LANES);
    localparam int unsigned AluShift = $clog2(ALU_LANES);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [BeatW-1:0] beat_q, beat_d;
    ctrl_word_t       ctrl_q, ctrl_d;
    logic             valid_q, valid_d;
    logic             multi_q, multi_d;
    ctrl_word_t       dec_ctrl;
    logic             dec_illegal;
    logic             accept;
    logic             go_idle;

    opcode_decoder #(
        .OpcodeWidth(OPCODE_WIDTH)
    ) u_decoder (
        .opcode_i (opcodeD),
        .ctrl_o   (dec_ctrl),
        .illegal_o(dec_illegal)
    );

    assign lastBeatE = valid_q & (~multi_q | (beat_q == BeatW'(Beats - 1)));
    assign readyD    = ~reset & ~stallE & ~flushE & ((state_q == StIdle) | lastBeatE);
    assign accept    = validD & readyD;
    assign go_idle   = flushE | (~stallE & ~accept & (state_q == StBusy) & lastBeatE);

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q, illegal_d;
    logic sticky_q, sticky_d;
    assign illegalOpE     = illegal_q;
    assign illegalStickyE = sticky_q;
`else
    logic unused_dec_illegal;
    assign unused_dec_illegal = dec_illegal;
    assign illegalOpE         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        multi_d = multi_q;
`ifdef ILLEGAL_OP_TRAP_EN
        illegal_d = illegal_q;
        sticky_d  = sticky_q;
`endif
        if (go_idle) begin
            state_d = StIdle;
            beat_d  = '0;
            ctrl_d  = CtrlNop;
            valid_d = 1'b0;
            multi_d = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_d = 1'b0;
`endif
        end else if (accept) begin
            state_d = StBusy;
            beat_d  = '0;
            ctrl_d  = dec_ctrl;
            valid_d = 1'b1;
            multi_d = dec_ctrl.we_vector_wb & ~dec_ctrl.use_scalar_alu & (Beats > 1);
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_d = dec_illegal;
            sticky_d  = sticky_q | dec_illegal;
`endif
        end else if (!stallE && state_q == StBusy) begin
            beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            beat_q  <= '0;
            ctrl_q  <= CtrlNop;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_q <= 1'b0;
            sticky_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_q <= illegal_d;
            sticky_q  <= sticky_d;
`endif
        end
    end

    assign validE                = valid_q;
    assign laneBaseE             = LaneW'(beat_q) << AluShift;
    assign useScalarAluE         = ctrl_q.use_scalar_alu;
    assign isScalarOutputE       = ctrl_q.is_scalar_output;
    assign isScalarReg1E         = ctrl_q.is_scalar_reg1;
    assign isScalarReg2E         = ctrl_q.is_scalar_reg2;
    assign resultSelectorWBE     = ctrl_q.result_selector_wb;
    assign writeEnableScalarWBE  = ctrl_q.we_scalar_wb;
    assign writeEnableVectorWBE  = ctrl_q.we_vector_wb;
    assign writeToMemoryEnableME = ctrl_q.wr_mem_m;
    assign useInmediateE         = ctrl_q.use_imm;
    assign outFlagME             = ctrl_q.out_flag_m;
    assign aluControlE           = ctrl_q.alu_control;

endmodule

// File: tb/tb_vector_control_sequencer.sv
// Randomized + directed bench: a beats-remaining reference model feeds a per-cycle scoreboard.
module tb_vector_control_sequencer;

    localparam int VL    = 8;
    localparam int AL    = 2;
    localparam int BEATS = VL / AL;
`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic       clk, reset, validD, readyD, stallE, flushE;
    logic [4:0] opcodeD;
    logic       useScalarAluE, isScalarOutputE, isScalarReg1E, isScalarReg2E;
    logic       resultSelectorWBE, writeEnableScalarWBE, writeEnableVectorWBE;
    logic       writeToMemoryEnableME, useInmediateE, outFlagME;
    logic [2:0] aluControlE;
    logic       validE, lastBeatE, illegalOpE, stickyE;
    logic [2:0] laneBaseE;

    vector_control_sequencer #(
        .OPCODE_WIDTH(5),
        .VECTOR_LANES(VL),
        .ALU_LANES   (AL)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .validD               (validD),
        .opcodeD              (opcodeD),
        .readyD               (readyD),
        .stallE               (stallE),
        .flushE               (flushE),
        .useScalarAluE        (useScalarAluE),
        .isScalarOutputE      (isScalarOutputE),
        .isScalarReg1E        (isScalarReg1E),
        .isScalarReg2E        (isScalarReg2E),
        .resultSelectorWBE    (resultSelectorWBE),
        .writeEnableScalarWBE (writeEnableScalarWBE),
        .writeEnableVectorWBE (writeEnableVectorWBE),
        .writeToMemoryEnableME(writeToMemoryEnableME),
        .useInmediateE        (useInmediateE),
        .outFlagME            (outFlagME),
        .aluControlE          (aluControlE),
        .validE               (validE),
        .laneBaseE            (laneBaseE),
        .lastBeatE            (lastBeatE),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegalStickyE       (stickyE),
`endif
        .illegalOpE           (illegalOpE)
    );

`ifndef ILLEGAL_OP_TRAP_EN
    assign stickyE = 1'b0;
`endif

    typedef struct {
        logic        valid;
        logic [12:0] word;
        logic [2:0]  lane;
        logic        last;
        logic        ill;
        logic        sticky;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: remaining beats of the instruction now on the E outputs.
    logic        m_active = 1'b0;
    logic [12:0] m_word   = '0;
    int          m_left   = 0;
    int          m_idx    = 0;
    logic        m_ill    = 1'b0;
    logic        m_sticky = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Bit order: scalar_alu, scalar_out, sreg1, sreg2, res_sel, we_s, we_v, wr_mem, imm, flag, alu
    function automatic logic [12:0] ref_word(input logic [4:0] op);
        logic usa, iso, sr1, sr2, rs, wes, wev, wm, imm, flg;
        logic [2:0] alu;
        {usa, iso, sr1, sr2, rs, wes, wev, wm, imm, flg, alu} = '0;
        case (op)
            5'h01: wev = 1'b1;
            5'h02: begin wev = 1'b1; alu = 3'd1; end
            5'h03: begin wev = 1'b1; alu = 3'd2; end
            5'h04: begin wev = 1'b1; imm = 1'b1; end
            5'h05: begin wev = 1'b1; sr2 = 1'b1; alu = 3'd1; end
            5'h06: begin wev = 1'b1; alu = 3'd3; end
            5'h07: begin wev = 1'b1; rs = 1'b1; imm = 1'b1; end
            5'h08: begin wm = 1'b1; imm = 1'b1; end
            5'h09: begin iso = 1'b1; wes = 1'b1; end
            5'h0A: begin usa = 1'b1; iso = 1'b1; wes = 1'b1; end
            5'h0B: begin usa = 1'b1; iso = 1'b1; wes = 1'b1; imm = 1'b1; end
            5'h0C: begin usa = 1'b1; iso = 1'b1; wes = 1'b1; rs = 1'b1; imm = 1'b1; end
            5'h0D: begin usa = 1'b1; wm = 1'b1; imm = 1'b1; end
            5'h0E: begin flg = 1'b1; alu = 3'd7; end
            5'h0F: begin wev = 1'b1; alu = 3'd4; end
            5'h10: begin wev = 1'b1; sr1 = 1'b1; alu = 3'd4; end
            default: ;
        endcase
        return {usa, iso, sr1, sr2, rs, wes, wev, wm, imm, flg, alu};
    endfunction

    function automatic logic model_ready(input logic r, input logic st, input logic fl);
        return !r && !st && !fl && (!m_active || m_left == 1);
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [4:0] op,
                              input logic st, input logic fl);
        logic rdy;
        exp_t e;
        rdy = model_ready(r, st, fl);
        if (r) begin
            m_active = 1'b0;
            m_ill    = 1'b0;
            m_sticky = 1'b0;
        end else if (fl) begin
            m_active = 1'b0;
        end else if (!st) begin
            if (v && rdy) begin
                m_active = 1'b1;
                m_word   = ref_word(op);
                m_idx    = 0;
                m_ill    = ILL_EN && (op > 5'h10);
                m_sticky = m_sticky | m_ill;
                // Vector writes not using the scalar ALU sweep all lane groups.
                m_left   = (m_word[6] && !m_word[12]) ? BEATS : 1;
            end else if (m_active) begin
                if (m_left == 1) begin
                    m_active = 1'b0;
                end else begin
                    m_left--;
                    m_idx++;
                end
            end
        end
        e.valid  = m_active;
        e.word   = m_active ? m_word : 13'd0;
        e.lane   = m_active ? 3'(m_idx * AL) : 3'd0;
        e.last   = m_active && (m_left == 1);
        e.ill    = m_active && m_ill;
        e.sticky = m_sticky;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic v, input logic [4:0] op,
                         input logic st, input logic fl);
        logic exp_rdy;
        @(negedge clk);
        reset   = r;
        validD  = v;
        opcodeD = op;
        stallE  = st;
        flushE  = fl;
        #1;
        exp_rdy = model_ready(r, st, fl);
        n_cmp++;
        if (readyD !== exp_rdy) begin
            n_err++;
            $display("FAIL readyD @%0t: got %b expected %b", $time, readyD, exp_rdy);
        end
        @(posedge clk);
        model_step(r, v, op, st, fl);
    endtask

    // Monitor: one expected E-stage snapshot per clock edge.
    initial begin
        exp_t e;
        logic [20:0] got, want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e    = exp_q.pop_front();
                got  = {validE, useScalarAluE, isScalarOutputE, isScalarReg1E, isScalarReg2E,
                        resultSelectorWBE, writeEnableScalarWBE, writeEnableVectorWBE,
                        writeToMemoryEnableME, useInmediateE, outFlagME, aluControlE,
                        laneBaseE, lastBeatE, illegalOpE, stickyE};
                want = {e.valid, e.word, e.lane, e.last, e.ill, e.sticky};
                n_cmp++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL e_outputs @%0t: got %h expected %h", $time, got, want);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; validD = 1'b0; opcodeD = '0; stallE = 1'b0; flushE = 1'b0;
        cycle(1, 0, 5'h00, 0, 0);
        cycle(1, 1, 5'h05, 1, 1);
        // Scalar add, single beat
        cycle(0, 1, 5'h0A, 0, 0);
        cycle(0, 0, 5'h00, 0, 0);
        // Vector op then scalar op held until the last beat
        cycle(0, 1, 5'h05, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 5'h0A, 0, 0);
        cycle(0, 0, 5'h00, 0, 0);
        // Stall for three cycles at lane base 2
        cycle(0, 1, 5'h07, 0, 0);
        cycle(0, 0, 5'h00, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 5'h01, 1, 0);
        cycle(0, 0, 5'h00, 0, 0);
        cycle(0, 0, 5'h00, 0, 0);
        cycle(0, 0, 5'h00, 0, 0);
        // Flush together with stall at lane base 4
        cycle(0, 1, 5'h07, 0, 0);
        cycle(0, 0, 5'h00, 0, 0);
        cycle(0, 0, 5'h00, 0, 0);
        cycle(0, 1, 5'h02, 1, 1);
        cycle(0, 0, 5'h00, 0, 0);
        // Illegal opcode
        cycle(0, 1, 5'h1F, 0, 0);
        cycle(0, 0, 5'h00, 0, 0);
        cycle(0, 1, 5'h03, 0, 0);
        cycle(0, 0, 5'h00, 0, 0);
        // Reset in the middle of a burst
        cycle(0, 1, 5'h05, 0, 0);
        cycle(0, 0, 5'h00, 0, 0);
        cycle(1, 0, 5'h00, 0, 0);
        cycle(0, 1, 5'h0E, 0, 0);
        cycle(0, 0, 5'h00, 0, 0);
        for (int i = 0; i < 600; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31))
                                             : 5'($urandom_range(0, 16));
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), op,
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 5));
        end
        cycle(0, 0, 5'h00, 0, 0);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
